// File: rtl/writeback_queue_pkg.sv
// Shared types for the writeback queue: result-select codes, write FSM states,
// queue entry layout and the enqueue-time result mux.
package writeback_queue_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_MEM = 2'b01,
        SRC_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_STROBE = 2'b10
    } wb_state_t;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] value;
    } wb_entry_t;

    // Code 2'b11 falls back to the ALU result.
    function automatic logic [DATA_W-1:0] select_result(
        input logic [1:0]        src,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] pc4
    );
        case (src)
            SRC_MEM: select_result = mem;
            SRC_PC4: select_result = pc4;
            default: select_result = alu;
        endcase
    endfunction

endpackage

// File: rtl/wbq_fifo.sv
// Small synchronous FIFO holding pending register-file writes.
// The head entry is presented combinationally so the write FSM can load it on the pop edge.
module wbq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers selected results, drains them to the register file with a
// SETUP/STROBE handshake, and tracks per-register pending writes for hazard queries.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [1:0]        in_resultsrc,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_pcplus4,
    input  logic              rsv_valid,
    input  logic [REG_W-1:0]  rsv_rd,
    input  logic [REG_W-1:0]  q_rs1,
    input  logic [REG_W-1:0]  q_rs2,
    output logic              q_busy1,
    output logic              q_busy2,
    output logic [REG_W-1:0]  A3,
    output logic [DATA_W-1:0] WD3,
    output logic              WE3,
    output logic              empty,
    output logic              ovf
);

    wb_state_t         state_reg, state_next;
    wb_entry_t         push_entry, head;
    logic              push, pop, fifo_full, fifo_empty;
    logic [REG_W-1:0]  a3_reg;
    logic [DATA_W-1:0] wd3_reg;
    logic              ovf_reg;

    // Writes to x0 are acknowledged but never queued.
    assign push             = in_valid && in_ready && (in_rd != '0);
    assign push_entry.rd    = in_rd;
    assign push_entry.value = select_result(in_resultsrc, in_alu, in_mem, in_pcplus4);

    wbq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign empty    = fifo_empty && (state_reg == ST_IDLE);
    assign WE3      = (state_reg == ST_STROBE);
    assign A3       = a3_reg;
    assign WD3      = wd3_reg;
    assign ovf      = ovf_reg;

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: state_next = ST_STROBE;
            ST_STROBE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_SETUP;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Address/data load only on a pop, which never coincides with WE3 staying high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            a3_reg    <= '0;
            wd3_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                a3_reg  <= head.rd;
                wd3_reg <= head.value;
            end
        end
    end

    logic [31:0] busy_vec;
    logic [31:0] err_vec;
    logic        inc;
    logic        dec;

    assign inc         = rsv_valid && (rsv_rd != '0);
    assign dec         = (state_reg == ST_STROBE);
    assign busy_vec[0] = 1'b0;
    assign err_vec[0]  = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_cnt
            logic [2:0] cnt_reg;
            logic       inc_hit;
            logic       dec_hit;

            assign inc_hit      = inc && (rsv_rd == REG_W'(gi));
            assign dec_hit      = dec && (a3_reg == REG_W'(gi));
            assign busy_vec[gi] = (cnt_reg != 3'd0);
            assign err_vec[gi]  = (inc_hit && !dec_hit && (cnt_reg == 3'd7)) ||
                                  (dec_hit && !inc_hit && (cnt_reg == 3'd0));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (inc_hit && !dec_hit && (cnt_reg != 3'd7)) begin
                    cnt_reg <= cnt_reg + 3'd1;
                end else if (dec_hit && !inc_hit && (cnt_reg != 3'd0)) begin
                    cnt_reg <= cnt_reg - 3'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_reg <= 1'b0;
        end else if (|err_vec) begin
            ovf_reg <= 1'b1;
        end
    end

    assign q_busy1 = busy_vec[q_rs1];
    assign q_busy2 = busy_vec[q_rs2];

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: a scoreboard of expected register-file
// writes plus directed checks of timing, hazard counters, overflow and reset.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [1:0]  in_resultsrc = '0;
    logic [31:0] in_alu = '0;
    logic [31:0] in_mem = '0;
    logic [31:0] in_pcplus4 = '0;
    logic        rsv_valid = 1'b0;
    logic [4:0]  rsv_rd = '0;
    logic [4:0]  q_rs1 = '0;
    logic [4:0]  q_rs2 = '0;
    logic        q_busy1, q_busy2;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic        empty;
    logic        ovf;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    int cycle = 0;
    logic        prev_we3 = 1'b0;
    logic        saw_not_ready = 1'b0;
    logic [36:0] sb[$];
    int          stimes[$];

    writeback_queue #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_resultsrc (in_resultsrc),
        .in_alu       (in_alu),
        .in_mem       (in_mem),
        .in_pcplus4   (in_pcplus4),
        .rsv_valid    (rsv_valid),
        .rsv_rd       (rsv_rd),
        .q_rs1        (q_rs1),
        .q_rs2        (q_rs2),
        .q_busy1      (q_busy1),
        .q_busy2      (q_busy2),
        .A3           (A3),
        .WD3          (WD3),
        .WE3          (WE3),
        .empty        (empty),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [1:0] src, input logic [31:0] alu,
                                                 input logic [31:0] mem, input logic [31:0] pc4);
        case (src)
            2'b01:   return mem;
            2'b10:   return pc4;
            default: return alu;
        endcase
    endfunction

    // Every register-file strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset) begin
            if (WE3) begin
                strobes++;
                stimes.push_back(cycle);
                $display("wb write a3=%0d wd3=%08h cycle=%0d", A3, WD3, cycle);
                if (prev_we3) chk("we3_gap", 1, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    logic [36:0] e;
                    e = sb.pop_front();
                    chk("a3", A3, e[36:32]);
                    chk("wd3", WD3, e[31:0]);
                end
            end
            prev_we3 = WE3;
        end else begin
            prev_we3 = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rsv(input logic [4:0] rd);
        rsv_valid = 1'b1;
        rsv_rd    = rd;
        step(1);
        rsv_valid = 1'b0;
    endtask

    task automatic enq(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc4);
        int waited = 0;
        in_valid = 1'b1; in_rd = rd; in_resultsrc = src;
        in_alu = alu; in_mem = mem; in_pcplus4 = pc4;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            saw_not_ready = 1'b1;
            waited++;
            if (waited > 50) begin
                chk("ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        if (rd != 5'd0) sb.push_back({rd, model_result(src, alu, mem, pc4)});
        $display("enq rd=%0d src=%0d waited=%0d", rd, src, waited);
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_we3(input string tag);
        int n = 0;
        while (!WE3) begin
            @(negedge clk);
            n++;
            if (n > 40) begin
                chk(tag, 0, 1);
                return;
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (!(empty && sb.size() == 0)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk(tag, 0, 1);
                return;
            end
        end
    endtask

    initial begin
        int s0;
        #2 reset = 1'b1;
        step(2);
        // reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_we3", WE3, 0);
        chk("rst_a3", A3, 0);
        chk("rst_wd3", WD3, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", q_busy1, 0);
        reset = 1'b0;
        step(1);

        // single write: SETUP one cycle after accept, STROBE the next
        q_rs1 = 5'd5;
        rsv(5'd5);
        chk("busy_5_pending", q_busy1, 1);
        enq(5'd5, 2'b00, 32'h0000_00AA, 32'h1111_1111, 32'h2222_2222);
        chk("single_not_empty", empty, 0);
        chk("single_we3_accept", WE3, 0);
        step(1);
        chk("setup_we3", WE3, 0);
        chk("setup_a3", A3, 5);
        chk("setup_wd3", WD3, 32'hAA);
        step(1);
        chk("strobe_we3", WE3, 1);
        step(1);
        chk("after_we3", WE3, 0);
        chk("after_empty", empty, 1);
        chk("busy_5_cleared", q_busy1, 0);

        // back-to-back burst fills the queue; drain at one write per two cycles
        for (int i = 1; i <= 8; i++) rsv(5'(i));
        stimes.delete();
        saw_not_ready = 1'b0;
        for (int i = 1; i <= 8; i++)
            enq(5'(i), 2'b01, 32'hA000 + i, 32'h10 + i - 1, 32'hC000 + i);
        chk("burst_saw_full", saw_not_ready, 1);
        wait_drain("burst_drain_timeout");
        chk("burst_strobe_count", stimes.size(), 8);
        for (int i = 1; i < stimes.size(); i++) chk("burst_spacing", stimes[i] - stimes[i-1], 2);

        // other result selects: PC+4, and code 11 falls back to ALU
        rsv(5'd4); rsv(5'd6);
        enq(5'd4, 2'b10, 32'h1, 32'h2, 32'h0000_1004);
        enq(5'd6, 2'b11, 32'hDEAD_BEEF, 32'h2, 32'h3);
        wait_drain("mux_drain_timeout");

        // write to x0 is accepted but never reaches the register file
        s0 = strobes;
        enq(5'd0, 2'b10, 32'h1, 32'h2, 32'h3);
        chk("x0_empty", empty, 1);
        step(6);
        chk("x0_no_strobe", strobes, s0);
        chk("x0_ovf", ovf, 0);

        // two reservations on x7: busy persists until the second write
        q_rs1 = 5'd7; q_rs2 = 5'd7;
        rsv(5'd7); rsv(5'd7);
        enq(5'd7, 2'b00, 32'h70, 32'h0, 32'h0);
        enq(5'd7, 2'b00, 32'h71, 32'h0, 32'h0);
        wait_we3("x7_first_timeout");
        step(1);
        chk("x7_busy_after_first", q_busy1, 1);
        @(negedge clk);
        wait_we3("x7_second_timeout");
        step(1);
        chk("x7_busy1_after_second", q_busy1, 0);
        chk("x7_busy2_after_second", q_busy2, 0);

        // reserve x3 on the same edge its write completes: count unchanged
        q_rs1 = 5'd3;
        rsv(5'd3);
        enq(5'd3, 2'b00, 32'h33, 32'h0, 32'h0);
        wait_we3("x3_timeout");
        rsv_valid = 1'b1; rsv_rd = 5'd3;
        step(1);
        rsv_valid = 1'b0;
        chk("x3_still_busy", q_busy1, 1);
        chk("x3_ovf", ovf, 0);

        // eight reservations on x9 saturate the 3-bit counter
        q_rs2 = 5'd9;
        for (int i = 0; i < 7; i++) rsv(5'd9);
        chk("x9_ovf_at7", ovf, 0);
        rsv(5'd9);
        chk("x9_ovf_at8", ovf, 1);
        chk("x9_busy", q_busy2, 1);
        step(2);
        chk("ovf_sticky", ovf, 1);

        // reset in the middle of a strobe with three writes still queued
        for (int i = 10; i <= 14; i++) rsv(5'(i));
        for (int i = 10; i <= 14; i++) enq(5'(i), 2'b00, 32'hB00 + i, 32'h0, 32'h0);
        chk("pre_rst_strobe", WE3, 1);
        chk("pre_rst_not_empty", empty, 0);
        reset = 1'b1;
        #1;
        chk("rst_mid_we3", WE3, 0);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_busy12", q_busy1, 0);
        q_rs1 = 5'd12; q_rs2 = 5'd13;
        #1;
        chk("rst_mid_busy1", q_busy1, 0);
        chk("rst_mid_busy2", q_busy2, 0);
        chk("rst_mid_ovf", ovf, 0);
        chk("rst_mid_ready", in_ready, 1);
        sb.delete();
        step(2);
        reset = 1'b0;
        s0 = strobes;
        step(10);
        chk("rst_no_strobes", strobes, s0);

        // first enqueue after reset is taken on the first edge
        q_rs1 = 5'd20;
        rsv(5'd20);
        enq(5'd20, 2'b01, 32'h0, 32'h2020_2020, 32'h0);
        chk("post_rst_accept", empty, 0);
        wait_drain("post_rst_drain_timeout");
        chk("post_rst_busy", q_busy1, 0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
